// File: rtl/onehot_scan_encoder_pkg.sv
// onehot_scan_pkg: shared types and helpers for the one-hot scan encoder.
// Optional feature macro used across the block: SCAN_LAST_EN (adds out_last).
package onehot_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index width for an n-bit vector, never narrower than one bit.
    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/onehot_scan_encoder_if.sv
// Handshake bundle between a multi-hot request source and the scan encoder.
// With SCAN_LAST_EN defined the bundle also carries out_last.
interface onehot_scan_encoder_if
    import onehot_scan_pkg::*;
#(
    parameter int N = 8
);
    localparam int W = idx_w(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
`ifdef SCAN_LAST_EN
    logic         out_last;
`endif
    logic         err_zero;

    // Producer/consumer side: drives requests, takes indices.
    modport master (
        output in_valid, in_vec, out_ready,
`ifdef SCAN_LAST_EN
        input  out_last,
`endif
        input  in_ready, out_valid, out_idx, err_zero
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_vec, out_ready,
`ifdef SCAN_LAST_EN
        output out_last,
`endif
        output in_ready, out_valid, out_idx, err_zero
    );

endinterface

// File: rtl/onehot_scan_encoder_lsb_index.sv
// lsb_index: combinational lowest-set-bit encoder; all-zero input yields 0.
module lsb_index
    import onehot_scan_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last writer.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder: accepts a multi-hot vector and emits the index of each
// set bit, lowest first, one per output handshake. All-zero vectors raise a
// one-cycle err_zero pulse instead of producing output.
// Optional: SCAN_LAST_EN drives out_last on the vector's final index.
module onehot_scan_encoder
    import onehot_scan_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    onehot_scan_encoder_if.slave    bus
);

    localparam int W = idx_w(N);

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic         err_q, err_d;
    logic [W-1:0] low_idx;
    logic [N-1:0] pend_rest;

    lsb_index #(.N(N)) u_lsb (
        .vec (pend_q),
        .idx (low_idx)
    );

    // pend with its lowest set bit cleared; zero means the current index is final.
    assign pend_rest = pend_q & (pend_q - N'(1));

    // State, pending bits and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Next-state: capture on accept in IDLE, retire one bit per handshake in SCAN.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (|bus.in_vec) begin
                        pend_d  = bus.in_vec;
                        state_d = SCAN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pend_d = pend_rest;
                    if (pend_rest == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on registered state only; pend is zero whenever IDLE.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == SCAN);
    assign bus.out_idx   = low_idx;
    assign bus.err_zero  = err_q;
`ifdef SCAN_LAST_EN
    assign bus.out_last  = (state_q == SCAN) && (pend_rest == '0);
`endif

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Directed bench for onehot_scan_encoder: N=8 and N=16 instances, expected
// indices queued at accept time and popped on each output handshake.
module tb_onehot_scan_encoder;

    typedef struct {
        int idx;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    onehot_scan_encoder_if #(.N(8))  ia ();
    onehot_scan_encoder_if #(.N(16)) ib ();

    onehot_scan_encoder #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(ia));
    onehot_scan_encoder #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(ib));

    exp_t qa[$];
    exp_t qb[$];
    int   total  = 0;
    int   passes = 0;
    int   n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pop and compare any handshake about to complete at the next rising edge.
    task automatic monitor();
        exp_t e;
        if (ia.out_valid === 1'b1 && ia.out_ready === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_out", 32'(ia.out_idx) + 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_idx", 32'(ia.out_idx), e.idx);
`ifdef SCAN_LAST_EN
                chk("a_last", 32'(ia.out_last), 32'(e.last));
`endif
            end
        end
        if (ib.out_valid === 1'b1 && ib.out_ready === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_out", 32'(ib.out_idx) + 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_idx", 32'(ib.out_idx), e.idx);
`ifdef SCAN_LAST_EN
                chk("b_last", 32'(ib.out_last), 32'(e.last));
`endif
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] v, input int w, input bit to_b);
        int hi;
        exp_t e;
        hi = -1;
        for (int i = 0; i < w; i++) if (v[i]) hi = i;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                e.idx  = i;
                e.last = (i == hi);
                if (to_b) qb.push_back(e);
                else      qa.push_back(e);
            end
        end
    endtask

    task automatic send8(input logic [7:0] v);
        ia.in_valid = 1'b1;
        ia.in_vec   = v;
        push_exp({8'h00, v}, 8, 1'b0);
        cyc();
        ia.in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] v);
        ib.in_valid = 1'b1;
        ib.in_vec   = v;
        push_exp(v, 16, 1'b1);
        cyc();
        ib.in_valid = 1'b0;
    endtask

    // Run cycles until both queues drain (bounded); returns cycles spent.
    task automatic drain(output int cycles);
        cycles = 0;
        while ((qa.size() != 0 || qb.size() != 0) && cycles < 40) begin
            cyc();
            cycles++;
        end
        chk("drain_qa_empty", qa.size(), 0);
        chk("drain_qb_empty", qb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ia.in_valid = 1'b0; ia.in_vec = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_vec = '0; ib.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(ia.out_valid), 0);
        chk("rst_in_ready",  32'(ia.in_ready), 1);
        chk("rst_err_zero",  32'(ia.err_zero), 0);
        chk("rst_out_idx",   32'(ia.out_idx), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(ia.in_ready), 1);
        @(posedge clk); #1;

        // Single bit
        ia.out_ready = 1'b1;
        send8(8'h01);
        drain(n);
        chk("single_cycles", n, 1);
        @(negedge clk);
        chk("single_in_ready",  32'(ia.in_ready), 1);
        chk("single_out_valid", 32'(ia.out_valid), 0);
        @(posedge clk); #1;

        // Multi-hot: four consecutive indices, then ready again
        send8(8'hA5);
        drain(n);
        chk("multi_cycles", n, 4);
        @(negedge clk);
        chk("multi_in_ready", 32'(ia.in_ready), 1);
        @(posedge clk); #1;

        // Backpressure; a new in_vec offered during SCAN must be ignored
        ia.out_ready = 1'b0;
        send8(8'h90);
        ia.in_valid = 1'b1;
        ia.in_vec   = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(ia.out_valid), 1);
            chk("bp_out_idx",   32'(ia.out_idx), 4);
            chk("bp_in_ready",  32'(ia.in_ready), 0);
            @(posedge clk); #1;
        end
        ia.in_valid  = 1'b0;
        ia.in_vec    = 8'h00;
        ia.out_ready = 1'b1;
        drain(n);
        chk("bp_cycles", n, 2);

        // Zero vector
        send8(8'h00);
        @(negedge clk);
        chk("zero_err_pulse", 32'(ia.err_zero), 1);
        chk("zero_out_valid", 32'(ia.out_valid), 0);
        chk("zero_in_ready",  32'(ia.in_ready), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_err_clear", 32'(ia.err_zero), 0);
        chk("zero_in_ready2", 32'(ia.in_ready), 1);
        @(posedge clk); #1;

        // Reset mid-scan
        send8(8'hFF);
        cyc();
        cyc();
        chk("mid_popped_two", qa.size(), 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(ia.out_valid), 0);
        chk("mid_rst_in_ready",  32'(ia.in_ready), 1);
        qa.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_mid_out_valid", 32'(ia.out_valid), 0);
            @(posedge clk); #1;
        end
        send8(8'h80);
        drain(n);
        chk("post_mid_cycles", n, 1);

        // N=16
        ib.out_ready = 1'b1;
        send16(16'h8001);
        drain(n);
        chk("n16_cycles", n, 2);
        @(negedge clk);
        chk("n16_in_ready", 32'(ib.in_ready), 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/onehot_scan_encoder.md
# onehot_scan_encoder

Parametrised, sequential successor to the combinational 8:3 encoder. Accepts an N-bit request vector over a valid/ready handshake and emits the binary index of every set bit, lowest first, one index per output handshake. It sits between multi-hot request sources (interrupt lines, channel-ready flags) and consumers that need one encoded index at a time. All-zero vectors are flagged instead of producing an undefined output.

## Interface
- N, default 8: request vector width; legal range 2..256.
- W, default $clog2(N): index width; derived localparam, not overridable.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  N  multi-hot request vector.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer takes out_idx.
- out_idx  output  W  binary index of the lowest pending set bit.
- out_last  output  1  present only with SCAN_LAST_EN; current index is the vector's final one.
- err_zero  output  1  one-cycle pulse: an all-zero vector was accepted.

## Operation
- Registers: state (IDLE, SCAN); pend[N-1:0]; err_zero.
- IDLE: in_ready=1, out_valid=0.
  - in_valid=1 and in_vec!=0: pend<=in_vec; state<=SCAN.
  - in_valid=1 and in_vec==0: vector consumed; err_zero<=1 for one cycle; state stays IDLE.
- SCAN: in_ready=0, out_valid=1, out_idx = index of lowest set bit of pend.
  - out_ready=1: clear that bit in pend. If it was the only set bit, state<=IDLE.
  - out_ready=0: pend, out_idx and out_last hold unchanged.
- out_last = (pend & (pend-1))==0 while in SCAN; 0 in IDLE.
- err_zero is 0 on every cycle except the one after a zero-vector accept.
- in_vec is sampled only on an accept. Changes to in_vec during SCAN are ignored.
- Reset values: state=IDLE, pend=0, out_valid=0, in_ready=1, out_idx=0, out_last=0, err_zero=0.
- Reset asserted mid-scan drops all remaining indices immediately. No partial output follows reset release.

## Timing
- Accept at edge k → out_valid=1 with the first index during cycle k+1.
- With out_ready held at 1, a vector with P set bits produces P indices on P consecutive cycles.
- After the final output handshake at edge m, in_ready=1 during cycle m+1. This is one bubble per vector; peak throughput is P/(P+1).
- out_idx, out_valid, out_last and in_ready are functions of registered state only. There is no combinational path from in_* to out_* or from out_ready to in_ready.
- A zero-vector accept at edge k → err_zero=1 during cycle k+1 only, with in_ready=1 throughout.

## Configuration
- SCAN_LAST_EN defined: the out_last port exists and is driven as described in Operation.
- SCAN_LAST_EN undefined: the out_last port and its logic are absent. All other behaviour is identical.

## Structure
- Package onehot_scan_pkg holds:
  - the state enum (IDLE, SCAN);
  - an index-width helper function that returns max(1, $clog2(N)).
- One sub-module, lsb_index: purely combinational.
  - Parameter N; input vec[N-1:0]; output idx[W-1:0].
  - Returns the lowest set-bit index, or 0 for an all-zero vec.
- The top level holds the FSM, pend, err_zero and the handshake logic.

## Test plan
- Reset: hold rst_n=0 → out_valid=0, in_ready=1, err_zero=0, out_idx=0. After release, in_ready=1.
- Single bit, N=8: accept 8'h01 with out_ready=1 → next cycle out_idx=0, out_last=1. The cycle after, in_ready=1 and out_valid=0.
- Multi-hot, N=8: accept 8'hA5 with out_ready=1 → out_idx=0,2,5,7 on four consecutive cycles. out_last=1 only with 7. The next cycle, in_ready=1.
- Backpressure, N=8: accept 8'h90 with out_ready=0 for 3 cycles → out_idx=4 held stable for 3 cycles. Then raise out_ready → 4, then 7 with out_last=1.
- Zero vector: accept 8'h00 → err_zero=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
- Reset mid-scan and parametrisation:
  - N=8: accept 8'hFF, take indices 0 and 1, then pulse rst_n low → out_valid=0 immediately. After release, accept 8'h80 → out_idx=7 only.
  - N=16: accept 16'h8001 → out_idx=0, then 15.
